// File: rtl/store_drain_unit.sv
// store_drain_unit: post-retirement store buffer between the store queue and
// the D-cache write port. Small circular FIFO, head drained with a
// valid/accept/miss handshake and fixed retry backoff, plus per-byte
// store-to-load forwarding from entries not yet written.
// Optional build macro: STORE_DRAIN_COALESCE_EN (merge a store into the
// youngest entry when the word address matches).
module store_drain_unit #(
  parameter int DEPTH      = 4,
  parameter int RETRY_WAIT = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_addr,
  input  logic [31:0]            in_data,
  input  logic [3:0]             in_byte_mask,
  output logic                   dc_req_valid,
  output logic [31:0]            dc_req_addr,
  output logic [31:0]            dc_req_data,
  output logic [3:0]             dc_req_byte_mask,
  input  logic                   dc_req_accepted,
  input  logic                   dc_req_miss,
  input  logic [31:0]            ld_addr,
  output logic [31:0]            fwd_data,
  output logic [3:0]             fwd_mask,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(RETRY_WAIT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_BACKOFF = 2'd2;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  mask;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW:0]   head, tail;
  logic [AW-1:0] head_idx, tail_idx, last_idx;
  logic [1:0]    state;
  logic [BW-1:0] backoff;
  logic          full, can_merge, enq, alloc, merge, deq;
  entry_t        head_e;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{in_addr[1:0], ld_addr[1:0]};

  assign head_idx = head[AW-1:0];
  assign tail_idx = tail[AW-1:0];
  assign last_idx = tail_idx - AW'(1);
  assign count    = tail - head;
  assign empty    = (head == tail);
  assign full     = (head_idx == tail_idx) && (head[AW] != tail[AW]);

`ifdef STORE_DRAIN_COALESCE_EN
  // The head may not be modified once it is being presented to the cache.
  assign can_merge = !empty && (mem[last_idx].waddr == in_addr[31:2]) &&
                     !((count == (AW+1)'(1)) && (state != S_IDLE));
  assign in_ready  = !full || can_merge;
`else
  assign can_merge = 1'b0;
  assign in_ready  = !full;
`endif

  assign enq   = in_valid && in_ready;
  assign merge = enq && can_merge;
  assign alloc = enq && !can_merge;
  assign deq   = dc_req_valid && dc_req_accepted;

  // Entry storage: allocate at tail or merge bytes into the youngest entry.
  always_ff @(posedge clock) begin
    if (alloc) begin
      mem[tail_idx] <= '{waddr: in_addr[31:2], data: in_data, mask: in_byte_mask};
    end else if (merge) begin
      for (int b = 0; b < 4; b++)
        if (in_byte_mask[b]) mem[last_idx].data[8*b +: 8] <= in_data[8*b +: 8];
      mem[last_idx].mask <= mem[last_idx].mask | in_byte_mask;
    end
  end

  // Head/tail pointers with wrap bit in the MSB.
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (alloc) tail <= tail + (AW+1)'(1);
      if (deq)   head <= head + (AW+1)'(1);
    end
  end

  // Drain FSM: present head, back off for RETRY_WAIT idle cycles on a miss.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      backoff <= '0;
    end else begin
      case (state)
        S_IDLE: if (!empty) state <= S_ISSUE;
        S_ISSUE: begin
          if (dc_req_accepted) begin
            if ((count == (AW+1)'(1)) && !enq) state <= S_IDLE;
          end else if (dc_req_miss) begin
            state   <= S_BACKOFF;
            backoff <= BW'(RETRY_WAIT);
          end
        end
        S_BACKOFF: begin
          backoff <= backoff - BW'(1);
          if (backoff == BW'(1)) state <= S_ISSUE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign head_e           = mem[head_idx];
  assign dc_req_valid     = (state == S_ISSUE);
  assign dc_req_addr      = dc_req_valid ? {head_e.waddr, 2'b00} : '0;
  assign dc_req_data      = dc_req_valid ? head_e.data : '0;
  assign dc_req_byte_mask = dc_req_valid ? head_e.mask : '0;

  // Forwarding: walk oldest to youngest so younger matches overwrite older.
  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((AW+1)'(i) < count) &&
          (mem[head_idx + AW'(i)].waddr == ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (mem[head_idx + AW'(i)].mask[b]) begin
            fwd_data[8*b +: 8] = mem[head_idx + AW'(i)].data[8*b +: 8];
            fwd_mask[b]        = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_store_drain_unit.sv
// Bench for store_drain_unit: directed scenarios plus random traffic, all
// checked each cycle against a queue-based reference model.
module tb_store_drain_unit;
  localparam int DEPTH      = 4;
  localparam int RETRY_WAIT = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_data;
  logic [3:0]  in_byte_mask;
  logic        dc_req_valid;
  logic [31:0] dc_req_addr, dc_req_data;
  logic [3:0]  dc_req_byte_mask;
  logic        dc_req_accepted, dc_req_miss;
  logic [31:0] ld_addr, fwd_data;
  logic [3:0]  fwd_mask;
  logic [2:0]  count;
  logic        empty;

  always #5 clock = ~clock;

  store_drain_unit #(.DEPTH(DEPTH), .RETRY_WAIT(RETRY_WAIT)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_byte_mask(in_byte_mask),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_byte_mask(dc_req_byte_mask),
    .dc_req_accepted(dc_req_accepted), .dc_req_miss(dc_req_miss),
    .ld_addr(ld_addr), .fwd_data(fwd_data), .fwd_mask(fwd_mask),
    .count(count), .empty(empty)
  );

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  // Reference model: buffered stores, oldest first, plus drain phase.
  ent_t q[$];
  int   phase;  // 0 idle, 1 presenting, 2 backing off
  int   left;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; dc_req_accepted = 1'b0; dc_req_miss = 1'b0;
    in_addr = '0; in_data = '0; in_byte_mask = '0; ld_addr = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    q.delete(); phase = 0; left = 0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_valid", 32'(dc_req_valid), 0);
    chk("rst_addr", dc_req_addr, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One clock: drive at negedge, check outputs, then advance the model.
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, input logic acc, input logic miss,
                     input logic [31:0] la);
    logic        p_valid, p_ready, mrg, enq, acc_e, miss_e;
    logic [31:0] e_fd;
    logic [3:0]  e_fm;
    int          sz0;
    ent_t        e;
    @(negedge clock);
    in_valid = v; in_addr = a; in_data = d; in_byte_mask = m;
    dc_req_accepted = acc; dc_req_miss = miss; ld_addr = la;
    #1;
    sz0 = q.size();
    p_valid = (phase == 1);
    mrg = 1'b0;
`ifdef STORE_DRAIN_COALESCE_EN
    mrg = (sz0 > 0) && (q[sz0-1].wa == a[31:2]) && !(sz0 == 1 && phase != 0);
`endif
    p_ready = (sz0 < DEPTH) || mrg;
    e_fd = '0; e_fm = '0;
    for (int b = 0; b < 4; b++)
      for (int j = sz0 - 1; j >= 0; j--)
        if (q[j].wa == la[31:2] && q[j].m[b]) begin
          e_fd[8*b +: 8] = q[j].d[8*b +: 8];
          e_fm[b] = 1'b1;
          break;
        end
    chk("count", 32'(count), 32'(sz0));
    chk("empty", 32'(empty), 32'(sz0 == 0));
    chk("in_ready", 32'(in_ready), 32'(p_ready));
    chk("req_valid", 32'(dc_req_valid), 32'(p_valid));
    chk("req_addr", dc_req_addr, p_valid ? {q[0].wa, 2'b00} : 32'h0);
    chk("req_data", dc_req_data, p_valid ? q[0].d : 32'h0);
    chk("req_mask", 32'(dc_req_byte_mask), p_valid ? 32'(q[0].m) : 32'h0);
    chk("fwd_data", fwd_data, e_fd);
    chk("fwd_mask", 32'(fwd_mask), 32'(e_fm));
    @(posedge clock);
    acc_e  = p_valid && acc;
    miss_e = p_valid && !acc && miss;
    enq    = v && p_ready;
    if (enq) begin
      if (mrg) begin
        e = q[sz0-1];
        for (int b = 0; b < 4; b++) if (m[b]) e.d[8*b +: 8] = d[8*b +: 8];
        e.m = e.m | m;
        q[sz0-1] = e;
      end else begin
        e.wa = a[31:2]; e.d = d; e.m = m;
        q.push_back(e);
      end
    end
    if (acc_e) void'(q.pop_front());
    case (phase)
      0: if (sz0 != 0) phase = 1;
      1: if (acc_e) begin
           if (sz0 - 1 == 0 && !enq) phase = 0;
         end else if (miss_e) begin
           phase = 2; left = RETRY_WAIT;
         end
      default: begin
        if (left == 1) phase = 1;
        left--;
      end
    endcase
  endtask

  task automatic idle(input int n, input logic acc);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 4'h0, acc, 1'b0, 32'h0);
  endtask

  initial begin
    do_reset();

    // Single store drained on the first presented cycle.
    cyc(1'b1, 32'h100, 32'hAABBCCDD, 4'hF, 1'b1, 1'b0, 32'h100);
    idle(4, 1'b1);

    // Fill to full, then accept with in_valid held; order preserved.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 4'hF, 1'b0, 1'b0, 32'h4);
    cyc(1'b1, 32'h10, 32'h55, 4'hF, 1'b0, 1'b0, 32'h8);
    cyc(1'b1, 32'h10, 32'h55, 4'hF, 1'b1, 1'b0, 32'hC);
    cyc(1'b1, 32'h10, 32'h55, 4'hF, 1'b1, 1'b0, 32'h10);
    idle(8, 1'b1);

    // Miss backoff, then accept and miss together.
    cyc(1'b1, 32'h200, 32'hCAFEF00D, 4'h5, 1'b0, 1'b0, 32'h200);
    cyc(1'b1, 32'h204, 32'h12345678, 4'hF, 1'b0, 1'b0, 32'h200);
    cyc(1'b0, 0, 0, 4'h0, 1'b0, 1'b1, 32'h200);
    for (int i = 0; i < 5; i++) cyc(1'b0, 0, 0, 4'h0, 1'b0, 1'b1, 32'h200);
    cyc(1'b0, 0, 0, 4'h0, 1'b1, 1'b1, 32'h204);
    idle(4, 1'b1);

    // Youngest-first forwarding across two entries to the same word.
    cyc(1'b1, 32'h40, 32'h11112222, 4'h3, 1'b0, 1'b0, 32'h41);
    cyc(1'b1, 32'h40, 32'h00003300, 4'h2, 1'b0, 1'b0, 32'h41);
    cyc(1'b0, 0, 0, 4'h0, 1'b0, 1'b0, 32'h41);
    #1;
    chk("fwd_dir_mask", 32'(fwd_mask), 32'h3);
    chk("fwd_dir_data", fwd_data, 32'h00003322);
    idle(5, 1'b1);

    // Continuous stream with accept every cycle: pointers wrap.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'h300 + 32'(i * 4), $urandom, 4'hF, 1'b1, 1'b0, 32'h300);
      chk("wrap_cnt_le2", 32'(count <= 3'd2), 1);
    end
    idle(4, 1'b1);

    // Two stores to the same word while the head is busy.
    cyc(1'b1, 32'h10, 32'hA0A0A0A0, 4'hF, 1'b0, 1'b0, 32'h80);
    cyc(1'b0, 0, 0, 4'h0, 1'b0, 1'b0, 32'h80);
    cyc(1'b1, 32'h80, 32'h000000AA, 4'h1, 1'b0, 1'b0, 32'h80);
    cyc(1'b1, 32'h80, 32'h0000BBCC, 4'h3, 1'b0, 1'b0, 32'h80);
    #1;
`ifdef STORE_DRAIN_COALESCE_EN
    chk("coal_count", 32'(count), 2);
`else
    chk("coal_count", 32'(count), 3);
`endif
    idle(6, 1'b1);

    // Random traffic with a mid-stream reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      cyc(1'($urandom_range(0, 1)),
          32'h500 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3)),
          $urandom, 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 3),
          32'h500 + 32'($urandom_range(0, 5) * 4));
    end
    idle(20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/store_drain_unit.md
Name: store_drain_unit

Overview:
Post-retirement store buffer that sits directly downstream of the store queue and upstream of the D-cache write port. It accepts retired, committed stores one per cycle and holds them in a small FIFO. It drains the FIFO head to the D-cache with a valid/accept/miss handshake and a fixed retry backoff. It also supplies per-byte store-to-load forwarding for entries not yet written to the cache.

Parameters:
DEPTH, 4, number of buffered stores; power of 2, minimum 2
RETRY_WAIT, 3, idle cycles after a D-cache miss before the request is re-presented; minimum 1

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
in_valid  in  1  retired store offered
in_ready  out  1  buffer can accept a store this cycle
in_addr  in  32  store byte address; bits [1:0] ignored, word-aligned
in_data  in  32  store data, byte lanes aligned to the word
in_byte_mask  in  4  bytes written
dc_req_valid  out  1  head store presented to the D-cache
dc_req_addr  out  32  head word address, bits [1:0] = 0
dc_req_data  out  32  head data
dc_req_byte_mask  out  4  head byte mask
dc_req_accepted  in  1  D-cache wrote the head this cycle
dc_req_miss  in  1  D-cache rejected the head this cycle (line fill pending)
ld_addr  in  32  load address for forwarding lookup
fwd_data  out  32  forwarded bytes; lanes without a match are 0
fwd_mask  out  4  lanes supplied by fwd_data
count  out  log2(DEPTH)+1  occupied entries
empty  out  1  count == 0

Behaviour:
- Storage: circular FIFO with head/tail pointers of log2(DEPTH)+1 bits, wrap bit as MSB. Full when the indices are equal and the wrap bits differ; empty when the pointers are equal.
- in_ready = (count < DEPTH). It depends on registered count only; a same-cycle dequeue does not open a slot.
- Enqueue when in_valid & in_ready: write the entry at tail and increment tail.
- Dequeue when dc_req_valid & dc_req_accepted: increment head. Enqueue and dequeue in the same cycle leave count unchanged.
- Drain FSM, reset state IDLE:
  - IDLE: dc_req_valid=0. Go to ISSUE when count != 0 (registered).
  - ISSUE: dc_req_valid=1, head fields driven.
    - If accepted: dequeue. Stay in ISSUE if count-1 != 0 or an enqueue occurs this cycle, else go to IDLE.
    - Else if miss: load the backoff counter with RETRY_WAIT and go to BACKOFF.
    - Else (neither): hold the request stable.
  - BACKOFF: dc_req_valid=0; decrement the counter; go to ISSUE on the cycle the counter reaches 1.
- If dc_req_accepted and dc_req_miss are both high, accepted wins and miss is ignored.
- Accept or miss inputs arriving while dc_req_valid=0 are ignored.
- dc_req_* fields hold stable while dc_req_valid=1 until accepted.
- Forwarding (combinational):
  - For each byte lane b, scan valid entries from youngest (tail-1) to oldest (head).
  - The first entry with addr[31:2] == ld_addr[31:2] and byte_mask[b]=1 supplies fwd_data byte b and sets fwd_mask[b].
  - The head entry being accepted this cycle still forwards, because state updates at the clock edge.
- Reset: head=tail=0, count=0, empty=1, in_ready=1, dc_req_valid=0, dc_req_addr/data/byte_mask=0, FSM=IDLE, backoff counter=0. Reset mid-request drops all buffered stores.
- Entry contents are don't-care when invalid; outputs are masked to 0 when dc_req_valid=0.

Optional Feature:
STORE_DRAIN_COALESCE_EN
- Defined: an incoming store whose word address equals the youngest valid entry's address is merged into that entry instead of allocating a new one.
  - Merge rule: per-byte, new bytes overwrite old; byte_mask is ORed; count is unchanged.
  - Merge is not allowed when that entry is the head and FSM is ISSUE or BACKOFF; a new entry is allocated instead.
  - in_ready=1 when full if a merge is possible this cycle.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset, then enqueue addr 0x100 / data 0xAABBCCDD / mask 0xF; cache accepts on the first valid cycle -> dc_req_valid rises the cycle after enqueue, fields match, count returns 0, FSM back to IDLE.
- Fill 4 stores with dc_req_accepted=0 -> in_ready=0 at count=4. Accept one with in_valid held -> no enqueue that cycle; enqueue the next cycle. Order is preserved: addresses 0x0, 0x4, 0x8, 0xC drained in order.
- Head at 0x200, assert dc_req_miss -> dc_req_valid low exactly 3 cycles, then re-presented with identical fields. Accept and miss together -> dequeue, no backoff.
- Entries 0x40 mask 0x3 data 0x11112222, then 0x40 mask 0x2 data 0x00003300; ld_addr 0x41 -> fwd_mask=0x3, fwd_data=0x00003322.
- Wrap: enqueue and drain 10 stores continuously with accept every cycle -> pointers wrap, no loss or duplication, count never exceeds 2.
- With STORE_DRAIN_COALESCE_EN: two stores to 0x80 while the head is busy with 0x10 -> count=2, merged mask OR, newest bytes win. Without the macro -> count=3.
